// File: rtl/bridge_pkg.sv
//------------------------------------------------------------------------------
// Module   : bridge_pkg
// Brief    : Shared types and constants for the AHB-to-APB bridge controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bridge_pkg;

   localparam int c_ADDR_W = 32;
   localparam int c_DATA_W = 32;
   localparam int c_NSLV   = 3;

   // APB slave address map: slave n occupies [c_SLVn_BASE, next base)
   localparam logic [31:0] c_SLV0_BASE = 32'h8000_0000;
   localparam logic [31:0] c_SLV1_BASE = 32'h8400_0000;
   localparam logic [31:0] c_SLV2_BASE = 32'h8800_0000;
   localparam logic [31:0] c_MAP_LIMIT = 32'h8C00_0000;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WWAIT    = 3'd1,
      W_SETUP  = 3'd2,
      W_ENABLE = 3'd3,
      R_SETUP  = 3'd4,
      R_ENABLE = 3'd5
   } bridge_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_bridge_fsm.sv
//------------------------------------------------------------------------------
// Module   : apb_bridge_fsm
// Brief    : AHB-to-APB sequencing controller; optional APB wait states via
//            the BRIDGE_PREADY_EN macro.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_bridge_fsm
   import bridge_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W,
   parameter int NSLV   = c_NSLV
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic [ADDR_W-1:0] haddr,
   input  logic              hwrite,
   input  logic [DATA_W-1:0] hwdata,
   input  logic [NSLV-1:0]   tempsel,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   output logic              hreadyout,
   output logic [DATA_W-1:0] hrdata,
   output logic [NSLV-1:0]   pselx,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata
);

   bridge_state_e     r_state;
   bridge_state_e     w_next_state;
   logic [ADDR_W-1:0] r_addr_q;
   logic [NSLV-1:0]   r_sel_q;
   logic              r_hreadyout;
   logic [DATA_W-1:0] r_hrdata;
   logic [NSLV-1:0]   r_pselx;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              w_done;

`ifdef BRIDGE_PREADY_EN
   assign w_done = pready;
`else
   logic w_unused_pready;
   assign w_unused_pready = pready;
   assign w_done          = 1'b1;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (valid) begin
               w_next_state = hwrite ? WWAIT : R_SETUP;
            end
         end
         WWAIT:    w_next_state = W_SETUP;
         W_SETUP:  w_next_state = W_ENABLE;
         W_ENABLE: w_next_state = w_done ? IDLE : W_ENABLE;
         R_SETUP:  w_next_state = R_ENABLE;
         R_ENABLE: w_next_state = w_done ? IDLE : R_ENABLE;
         default:  w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_addr_q    <= '0;
         r_sel_q     <= '0;
         r_hreadyout <= 1'b1;
         r_hrdata    <= '0;
         r_pselx     <= '0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (valid) begin
                  r_hreadyout <= 1'b0;
                  // Writes wait one cycle for hwdata in the AHB data phase
                  if (hwrite) begin
                     r_addr_q <= haddr;
                     r_sel_q  <= tempsel;
                  end else begin
                     r_paddr  <= haddr;
                     r_pselx  <= tempsel;
                     r_pwrite <= 1'b0;
                  end
               end
            end
            WWAIT: begin
               r_paddr  <= r_addr_q;
               r_pselx  <= r_sel_q;
               r_pwrite <= 1'b1;
               r_pwdata <= hwdata;
            end
            W_SETUP, R_SETUP: begin
               r_penable <= 1'b1;
            end
            W_ENABLE, R_ENABLE: begin
               if (w_done) begin
                  r_pselx     <= '0;
                  r_penable   <= 1'b0;
                  r_hreadyout <= 1'b1;
                  if (r_state == R_ENABLE) begin
                     r_hrdata <= prdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign hreadyout = r_hreadyout;
   assign hrdata    = r_hrdata;
   assign pselx     = r_pselx;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_bridge_fsm.sv
//------------------------------------------------------------------------------
// Module   : tb_apb_bridge_fsm
// Brief    : Scoreboard bench for apb_bridge_fsm (honours BRIDGE_PREADY_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_apb_bridge_fsm;
   import bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] haddr = '0;
   logic        hwrite = 1'b0;
   logic [31:0] hwdata = '0;
   logic [2:0]  tempsel = '0;
   logic [31:0] prdata = '0;
   logic        pready = 1'b1;
   logic        hreadyout;
   logic [31:0] hrdata;
   logic [2:0]  pselx;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;

`ifdef BRIDGE_PREADY_EN
   localparam bit c_WAITS = 1'b1;
`else
   localparam bit c_WAITS = 1'b0;
`endif

   apb_bridge_fsm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (valid),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .hwdata    (hwdata),
      .tempsel   (tempsel),
      .prdata    (prdata),
      .pready    (pready),
      .hreadyout (hreadyout),
      .hrdata    (hrdata),
      .pselx     (pselx),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  sel;
      logic [31:0] wdata;
      int          en_cyc;
   } apb_t;

   typedef struct {
      int          cyc;
      logic [31:0] hrdata;
   } done_t;

   apb_t  q_apb[$];
   done_t q_done[$];
   int    n_pass = 0;
   int    n_total = 0;
   int    cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: one transfer in flight; timeline derived from the protocol rules
   bit          m_busy = 1'b0;
   apb_t        m_cur;
   done_t       m_done;
   logic [31:0] m_hrdata = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy   = 1'b0;
         m_hrdata = '0;
         q_apb.delete();
         q_done.delete();
      end else if (!m_busy) begin
         if (valid) begin
            m_cur.wr     = hwrite;
            m_cur.addr   = haddr;
            m_cur.sel    = tempsel;
            m_cur.wdata  = '0;
            m_cur.en_cyc = cyc + (hwrite ? 3 : 2);
            m_busy       = 1'b1;
            if (!hwrite) q_apb.push_back(m_cur);
         end
      end else begin
         if (m_cur.wr && cyc == m_cur.en_cyc - 2) begin
            m_cur.wdata = hwdata;
            q_apb.push_back(m_cur);
         end
         if (cyc >= m_cur.en_cyc && (!c_WAITS || pready)) begin
            if (!m_cur.wr) m_hrdata = prdata;
            m_done.cyc    = cyc + 1;
            m_done.hrdata = m_hrdata;
            q_done.push_back(m_done);
            m_busy = 1'b0;
         end
      end
      cyc++;
   end

   // Monitor: compares the DUT against the queued expectations
   logic  p_hr = 1'b1;
   logic  p_en = 1'b0;
   apb_t  mon_e;
   done_t mon_d;

   always @(negedge clk) begin
      if (!rst_n) begin
         p_hr = 1'b1;
         p_en = 1'b0;
      end else begin
         chk("pselx_onehot0", 64'($onehot0(pselx)), 64'd1);
         if (hreadyout) chk("idle_psel_pen", {pselx, penable}, 4'b0);
         if (penable && !p_en) begin
            if (q_apb.size() == 0) begin
               chk("unexpected_apb_access", 1, 0);
            end else begin
               mon_e = q_apb.pop_front();
               chk("enable_cycle", cyc, mon_e.en_cyc);
               chk("paddr", paddr, mon_e.addr);
               chk("pwrite", pwrite, mon_e.wr);
               chk("pselx", pselx, mon_e.sel);
               if (mon_e.wr) chk("pwdata", pwdata, mon_e.wdata);
            end
         end else if (penable && p_en) begin
            chk("wait_paddr_stable", paddr, mon_e.addr);
            chk("wait_pselx_stable", pselx, mon_e.sel);
            if (mon_e.wr) chk("wait_pwdata_stable", pwdata, mon_e.wdata);
         end
         if (hreadyout && !p_hr) begin
            if (q_done.size() == 0) begin
               chk("unexpected_completion", 1, 0);
            end else begin
               mon_d = q_done.pop_front();
               chk("done_cycle", cyc, mon_d.cyc);
               chk("hrdata", hrdata, mon_d.hrdata);
            end
         end
         p_hr = hreadyout;
         p_en = penable;
      end
   end

   task automatic drive(input bit v, input bit w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd, input logic [31:0] rd, input bit rdy);
      @(negedge clk);
      #1;
      valid   = v;
      hwrite  = w;
      haddr   = a;
      tempsel = s;
      hwdata  = wd;
      prdata  = rd;
      pready  = rdy;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, '0, '0, '0, '0, 1);
   endtask

   initial begin
      int          reg_n;
      logic [31:0] a;
      logic [2:0]  s;
      bit          got;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_hreadyout", hreadyout, 1);
      chk("rst_pselx", pselx, 0);
      chk("rst_penable", penable, 0);
      chk("rst_hrdata", hrdata, 0);
      chk("rst_paddr_pwrite", {paddr, pwrite}, 0);
      #1 rst_n = 1'b1;
      idle(2);

      // Directed write, then read
      drive(1, 1, 32'h8000_0010, 3'b001, '0, '0, 1);
      drive(0, 0, '0, '0, 32'hDEAD_BEEF, '0, 1);
      idle(4);
      drive(1, 0, 32'h8400_0004, 3'b010, '0, 32'h1234_5678, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, '0, '0, '0, 32'h1234_5678, 1);

      // Back-to-back: read presented in the write's completion cycle
      drive(1, 1, 32'h8800_0000, 3'b100, '0, '0, 1);
      drive(0, 0, '0, '0, 32'hCAFE_0001, '0, 1);
      idle(2);
      drive(1, 0, 32'h8000_0008, 3'b001, '0, 32'h0BAD_F00D, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, '0, '0, '0, 32'h0BAD_F00D, 1);

      // valid held while busy must be ignored
      drive(1, 1, 32'h8400_0020, 3'b010, '0, '0, 1);
      drive(1, 1, 32'h8800_0040, 3'b100, 32'h5555_AAAA, '0, 1);
      idle(5);

      // Stalled read: pready low for three enable cycles
      drive(1, 0, 32'h8400_0100, 3'b010, '0, 32'hA5A5_0000, 1);
      drive(0, 0, '0, '0, '0, 32'hA5A5_0001, 1);
      for (int i = 0; i < 3; i++) drive(0, 0, '0, '0, '0, 32'hA5A5_0002 + i, 0);
      drive(0, 0, '0, '0, '0, 32'hA5A5_00FF, 1);
      idle(4);

      // Reset asserted during W_ENABLE
      drive(1, 1, 32'h8800_0010, 3'b100, '0, '0, 0);
      drive(0, 0, '0, '0, 32'h7777_8888, '0, 0);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         drive(0, 0, '0, '0, '0, '0, 0);
         got = penable && pwrite;
      end
      chk("reached_w_enable", got, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_pselx", pselx, 0);
      chk("midrst_penable", penable, 0);
      chk("midrst_hreadyout", hreadyout, 1);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         reg_n = (($urandom % 16) == 0) ? 3 : int'($urandom % 3);
         a = 32'h8000_0000 + (reg_n * 32'h0400_0000) + ($urandom & 32'h03FF_FFFC);
         s = (reg_n < 3) ? 3'(1 << reg_n) : 3'b000;
         drive(($urandom % 3) != 0, $urandom % 2, a, s, $urandom, $urandom, ($urandom % 4) != 0);
      end

      // Drain with a bounded wait
      for (int i = 0; i < 20 && m_busy; i++) idle(1);
      idle(3);
      chk("drain_model_idle", m_busy, 0);
      chk("apb_queue_empty", q_apb.size(), 0);
      chk("done_queue_empty", q_done.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
